ps2_mouse_ctrl: RTL

PS2_MOUSE_CTRL -- requirements
Module: ps2_mouse_ctrl

---
 rtl/ps2_mouse_pkg.sv | 65 ++++++
 rtl/ps2_mouse_pos_accum.sv | 59 +++++
 rtl/ps2_mouse_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse controller.
// States, command/response bytes, header decode and screen bounds live here.
package ps2_mouse_pkg;

    // Top-level controller sequence.
    typedef enum logic [3:0] {
        StSendRst,
        StWaitRstAck,
        StWaitBat,
        StWaitId,
        StSendEn,
        StWaitEnAck,
        StStreamB1,
        StStreamB2,
        StStreamB3,
        StFail
    } state_e;

    // Sub-steps inside a send state: settle, strobe, then wait for the controller.
    typedef enum logic [1:0] {
        PhEnter,
        PhArm,
        PhWait
    } send_phase_e;

    // Byte 1 of a movement packet, minus the always-one sync bit.
    typedef struct packed {
        logic yovf;
        logic xovf;
        logic ysign;
        logic xsign;
        logic btn_m;
        logic btn_r;
        logic btn_l;
    } pkt_hdr_t;

    localparam logic [7:0] CmdReset  = 8'hFF;
    localparam logic [7:0] CmdEnable = 8'hF4;
    localparam logic [7:0] RespAck   = 8'hFA;
    localparam logic [7:0] RespBat   = 8'hAA;
    localparam logic [7:0] RespId    = 8'h00;

    localparam int unsigned ScreenW  = 640;
    localparam int unsigned ScreenH  = 480;
    localparam int unsigned PosXMax  = ScreenW - 1;
    localparam int unsigned PosYMax  = ScreenH - 1;
    localparam int unsigned PosXInit = 320;
    localparam int unsigned PosYInit = 240;

    function automatic pkt_hdr_t decode_hdr(logic [7:0] b);
        pkt_hdr_t h;
        h = {b[7:4], b[2:0]};
        return h;
    endfunction

    // Byte the mouse must return while the controller sits in a wait state.
    function automatic logic [7:0] expected_resp(state_e s);
        case (s)
            StWaitBat: return RespBat;
            StWaitId:  return RespId;
            default:   return RespAck;
        endcase
    endfunction

endpackage

// File: rtl/ps2_mouse_pos_accum.sv
// Saturating cursor accumulator: pos_x += dx, pos_y -= dy on each packet,
// clamped to the visible screen. Only instantiated when MOUSE_POS_EN is defined.
module ps2_mouse_pos_accum
    import ps2_mouse_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              upd_i,
    input  logic signed [8:0] dx_i,
    input  logic signed [8:0] dy_i,
    output logic [9:0]        pos_x_o,
    output logic [8:0]        pos_y_o
);

    logic [9:0]         pos_x_q, pos_x_d;
    logic [8:0]         pos_y_q, pos_y_d;
    logic signed [11:0] x_sum;
    logic signed [10:0] y_sum;

    // Widen, add the signed delta, then clamp into the screen rectangle.
    always_comb begin
        x_sum   = $signed({2'b00, pos_x_q}) + $signed({{3{dx_i[8]}}, dx_i});
        y_sum   = $signed({2'b00, pos_y_q}) - $signed({{2{dy_i[8]}}, dy_i});
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (upd_i) begin
            if (x_sum[11]) begin
                pos_x_d = '0;
            end else if (x_sum[10:0] > 11'(PosXMax)) begin
                pos_x_d = 10'(PosXMax);
            end else begin
                pos_x_d = x_sum[9:0];
            end
            // Mouse Y grows upward, screen Y grows downward.
            if (y_sum[10]) begin
                pos_y_d = '0;
            end else if (y_sum[9:0] > 10'(PosYMax)) begin
                pos_y_d = 9'(PosYMax);
            end else begin
                pos_y_d = y_sum[8:0];
            end
        end
    end

    // Position registers, reset to screen centre.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pos_x_q <= 10'(PosXInit);
            pos_y_q <= 9'(PosYInit);
        end else begin
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
        end
    end

    assign pos_x_o = pos_x_q;
    assign pos_y_o = pos_y_q;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse init + stream decoder sitting on top of a byte-level PS2_Controller.
// Resets the mouse, checks ACK/BAT/ID, enables streaming, then decodes 3-byte
// movement packets. Define MOUSE_POS_EN to add a saturating cursor position.
module ps2_mouse_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned RETRY_MAX   = 3,
    parameter int unsigned TIMEOUT_CYC = 25_000_000,
    parameter int unsigned GAP_CYC     = 1_000_000
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    output logic [7:0]        cmd_data,
    output logic              cmd_en,
    input  logic              cmd_sent,
    input  logic              cmd_timeout,
    input  logic [7:0]        rx_data,
    input  logic              rx_en,
    output logic              init_done,
    output logic              init_error,
    output logic              btn_l,
    output logic              btn_m,
    output logic              btn_r,
    output logic signed [8:0] dx,
    output logic signed [8:0] dy,
    output logic              pkt_valid,
    output logic [9:0]        pos_x,
    output logic [8:0]        pos_y
);

    localparam int unsigned RetryW = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);

    state_e            state_q, state_d;
    send_phase_e       phase_q, phase_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [31:0]       tmr_q, tmr_d;
    pkt_hdr_t          hdr_q, hdr_d;
    logic [7:0]        xbyte_q, xbyte_d;

    logic              cmd_en_q, cmd_en_d;
    logic [7:0]        cmd_data_q, cmd_data_d;
    logic              init_done_q, init_done_d;
    logic              init_error_q, init_error_d;
    logic              pkt_valid_q, pkt_valid_d;
    logic [2:0]        btn_q, btn_d;   // {m, r, l}
    logic signed [8:0] dx_q, dx_d;
    logic signed [8:0] dy_q, dy_d;

    logic              restart;
    logic              step_tmo;
    logic              gap_tmo;

    // Next-state and output decode; any init fault funnels through 'restart'.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        retry_d      = retry_q;
        tmr_d        = tmr_q + 32'd1;
        hdr_d        = hdr_q;
        xbyte_d      = xbyte_q;
        restart      = 1'b0;
        cmd_en_d     = 1'b0;
        cmd_data_d   = cmd_data_q;
        init_done_d  = init_done_q;
        init_error_d = init_error_q;
        pkt_valid_d  = 1'b0;
        btn_d        = btn_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        step_tmo     = (tmr_q >= TIMEOUT_CYC - 1);
        gap_tmo      = (tmr_q >= GAP_CYC - 1);

        unique case (state_q)
            StSendRst, StSendEn: begin
                cmd_data_d = (state_q == StSendRst) ? CmdReset : CmdEnable;
                unique case (phase_q)
                    PhEnter: phase_d = PhArm;
                    PhArm: begin
                        cmd_en_d = 1'b1;
                        phase_d  = PhWait;
                    end
                    default: begin
                        if (cmd_timeout || step_tmo) begin
                            restart = 1'b1;
                        end else if (cmd_sent) begin
                            state_d = (state_q == StSendRst) ? StWaitRstAck : StWaitEnAck;
                        end
                    end
                endcase
            end
            StWaitRstAck, StWaitBat, StWaitId, StWaitEnAck: begin
                if (rx_en) begin
                    if (rx_data != expected_resp(state_q)) begin
                        restart = 1'b1;
                    end else begin
                        unique case (state_q)
                            StWaitRstAck: state_d = StWaitBat;
                            StWaitBat:    state_d = StWaitId;
                            StWaitId:     state_d = StSendEn;
                            default: begin
                                state_d     = StStreamB1;
                                init_done_d = 1'b1;
                            end
                        endcase
                    end
                end else if (step_tmo) begin
                    restart = 1'b1;
                end
            end
            StStreamB1: begin
                tmr_d = '0;
                // Bit 3 is always set in a header byte; anything else is dropped to resync.
                if (rx_en && rx_data[3]) begin
                    hdr_d   = decode_hdr(rx_data);
                    state_d = StStreamB2;
                end
            end
            StStreamB2: begin
                if (rx_en) begin
                    xbyte_d = rx_data;
                    state_d = StStreamB3;
                end else if (gap_tmo) begin
                    state_d = StStreamB1;
                end
            end
            StStreamB3: begin
                if (rx_en) begin
                    pkt_valid_d = 1'b1;
                    btn_d       = {hdr_q.btn_m, hdr_q.btn_r, hdr_q.btn_l};
                    dx_d        = hdr_q.xovf ? '0 : {hdr_q.xsign, xbyte_q};
                    dy_d        = hdr_q.yovf ? '0 : {hdr_q.ysign, rx_data};
                    state_d     = StStreamB1;
                end else if (gap_tmo) begin
                    state_d = StStreamB1;
                end
            end
            default: begin
                tmr_d = '0;
            end
        endcase

        if (restart) begin
            retry_d = retry_q + 1'b1;
            if (32'(retry_q) + 32'd1 >= RETRY_MAX) begin
                state_d      = StFail;
                init_error_d = 1'b1;
            end else begin
                state_d = StSendRst;
            end
        end

        // A restart re-enters StSendRst from itself, so it must rearm explicitly.
        if (restart || (state_d != state_q)) begin
            tmr_d   = '0;
            phase_d = PhEnter;
        end
    end

    // Sequencer state, retry count, step timer and packet capture.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StSendRst;
            phase_q <= PhEnter;
            retry_q <= '0;
            tmr_q   <= '0;
            hdr_q   <= '0;
            xbyte_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            retry_q <= retry_d;
            tmr_q   <= tmr_d;
            hdr_q   <= hdr_d;
            xbyte_q <= xbyte_d;
        end
    end

    // Registered outputs so every port is glitch-free and clears on reset.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cmd_en_q     <= 1'b0;
            cmd_data_q   <= '0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            pkt_valid_q  <= 1'b0;
            btn_q        <= '0;
            dx_q         <= '0;
            dy_q         <= '0;
        end else begin
            cmd_en_q     <= cmd_en_d;
            cmd_data_q   <= cmd_data_d;
            init_done_q  <= init_done_d;
            init_error_q <= init_error_d;
            pkt_valid_q  <= pkt_valid_d;
            btn_q        <= btn_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
        end
    end

    assign cmd_en     = cmd_en_q;
    assign cmd_data   = cmd_data_q;
    assign init_done  = init_done_q;
    assign init_error = init_error_q;
    assign pkt_valid  = pkt_valid_q;
    assign btn_l      = btn_q[0];
    assign btn_r      = btn_q[1];
    assign btn_m      = btn_q[2];
    assign dx         = dx_q;
    assign dy         = dy_q;

`ifdef MOUSE_POS_EN
    ps2_mouse_pos_accum u_pos_accum (
        .clk_i   (CLOCK_50),
        .rst_ni  (reset_n),
        .upd_i   (pkt_valid_q),
        .dx_i    (dx_q),
        .dy_i    (dy_q),
        .pos_x_o (pos_x),
        .pos_y_o (pos_y)
    );
`else
    assign pos_x = '0;
    assign pos_y = '0;
`endif

endmodule
